// File: rtl/nbldpc_addr_pkg.sv
// -----------------------------------------------------------------------------
// nbldpc_addr_pkg
// Shared types and helpers for the NB-LDPC message-memory address generators.
//   addr_gen_state_t : FSM encoding for the strided address generator.
//   mod_add()        : (a + b) mod limit using a single conditional
//                      subtraction; exact only when a < limit and b < limit.
// -----------------------------------------------------------------------------
package nbldpc_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addr_gen_state_t;

    // Operates on 32-bit operands so one function serves every generator width.
    // The sum is carried one bit wider so the carry-out is never lost before
    // the comparison against limit.
    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] limit);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, limit}) begin
            s = s - {1'b0, limit};
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/addr_mod_add.sv
// -----------------------------------------------------------------------------
// addr_mod_add
// Combinational modular increment: y = (a + b) mod LIMIT.
// A single conditional subtraction is used, so the result is exact only when
// a < LIMIT and b < LIMIT.
// Ports:
//   a  in  WIDTH : current address
//   b  in  WIDTH : increment
//   y  out WIDTH : wrapped next address
// -----------------------------------------------------------------------------
module addr_mod_add #(
    parameter int WIDTH = 10,
    parameter int LIMIT = 1024
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // LIMIT may equal 2^WIDTH, so it needs the extra bit as well.
    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           wrap;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = sum - LIM;
    assign wrap = (sum >= LIM);
    assign y    = wrap ? diff[WIDTH-1:0] : sum[WIDTH-1:0];

endmodule

// File: rtl/addr_gen_stride.sv
// -----------------------------------------------------------------------------
// addr_gen_stride
// Strided address generator for the NB-LDPC message memories. Walks `length`
// addresses starting at `start_addr` in steps of `step`, modulo LIMIT.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : load start_addr/step/length and begin a sequence
//   enable              : consumer accepted the current address
//   start_addr, step    : sequence origin and increment (must be < LIMIT)
//   length              : number of addresses (0 gives an immediate done)
//   count               : current address
//   valid, last         : count is live / count is the final address
//   done                : one-cycle pulse after the final address is consumed
//   busy                : FSM is not IDLE
//
// Handshake: an address is transferred on every rising edge where valid and
// enable are both high. count/valid/last hold while enable is low. enable is
// ignored whenever valid is low. start wins over enable and restarts the walk
// without a done pulse for the abandoned sequence.
// -----------------------------------------------------------------------------
module addr_gen_stride
    import nbldpc_addr_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int LEN_W = 10,
    parameter int LIMIT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [WIDTH-1:0] start_addr,
    input  logic [WIDTH-1:0] step,
    input  logic [LEN_W-1:0] length,
    output logic [WIDTH-1:0] count,
    output logic             valid,
    output logic             last,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(LIMIT);

    addr_gen_state_t  state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] next_addr;

    addr_mod_add #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_mod_add (
        .a (count_q),
        .b (step_q),
        .y (next_addr)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        step_d      = step_q;

        // DONE always falls back to IDLE unless a new start arrives.
        if (state_q == DONE) begin
            state_d = IDLE;
        end

        if (start) begin
            // Accepted identically from IDLE, RUN (restart) and DONE.
            if (length != '0) begin
                state_d     = RUN;
                count_d     = start_addr;
                remaining_d = length - LEN_W'(1);
                step_d      = step;
            end else begin
                // Empty sequence: skip RUN entirely, count is left alone.
                state_d = DONE;
            end
        end else if (state_q == RUN && enable) begin
            if (remaining_q != '0) begin
                count_d     = next_addr;
                remaining_d = remaining_q - LEN_W'(1);
            end else begin
                // Final address consumed; count keeps showing it.
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            remaining_q <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            step_q      <= step_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign count = count_q;
    assign valid = (state_q == RUN);
    assign last  = (state_q == RUN) && (remaining_q == '0);
    assign done  = (state_q == DONE);
    assign busy  = (state_q != IDLE);

    // The single-subtraction wrap is only exact for in-range operands.
    always_ff @(posedge clk) begin
        if (!reset && start) begin
            assert (({1'b0, start_addr} < LIM) && ({1'b0, step} < LIM))
                else $error("addr_gen_stride: start_addr or step not below LIMIT");
        end
    end

endmodule

// File: tb/tb_addr_gen_stride.sv
// -----------------------------------------------------------------------------
// tb_addr_gen_stride
// Directed bench for addr_gen_stride. Two instances: dut_a with the default
// LIMIT=1024 and dut_b with LIMIT=15. A reference walk is pushed into exp_q
// whenever a start is driven and popped as each address is consumed.
// -----------------------------------------------------------------------------
module tb_addr_gen_stride;

  localparam int W  = 10;
  localparam int LW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_a, start_b, enable;
  logic [W-1:0]  start_addr, step;
  logic [LW-1:0] length;

  logic [W-1:0] count_a, count_b;
  logic valid_a, last_a, done_a, busy_a;
  logic valid_b, last_b, done_b, busy_b;

  addr_gen_stride #(.WIDTH(W), .LEN_W(LW), .LIMIT(1024)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .enable(enable),
    .start_addr(start_addr), .step(step), .length(length),
    .count(count_a), .valid(valid_a), .last(last_a), .done(done_a), .busy(busy_a)
  );

  addr_gen_stride #(.WIDTH(W), .LEN_W(LW), .LIMIT(15)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .enable(enable),
    .start_addr(start_addr), .step(step), .length(length),
    .count(count_b), .valid(valid_b), .last(last_b), .done(done_b), .busy(busy_b)
  );

  // Which instance is under observation.
  bit sel;
  logic [W-1:0] o_count;
  logic o_valid, o_last, o_done, o_busy;
  assign o_count = sel ? count_b : count_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_last  = sel ? last_b  : last_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_busy  = sel ? busy_b  : busy_a;

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_count;
  bit exp_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Independent reference: plain integer modulo.
  task automatic push_seq(input int a, input int s, input int len, input int lim);
    int cur;
    cur = a;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(W'(cur));
      cur = (cur + s) % lim;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare current outputs, then account for what the upcoming edge does.
  task automatic observe(input string tag, input bit st);
    bit exp_valid;
    exp_valid = (exp_q.size() > 0);
    chk({tag, "_valid"}, 32'(o_valid), 32'(exp_valid));
    chk({tag, "_done"},  32'(o_done),  32'(exp_done));
    chk({tag, "_busy"},  32'(o_busy),  32'(exp_valid || exp_done));
    chk({tag, "_count"}, 32'(o_count), 32'(exp_count));
    chk({tag, "_last"},  32'(o_last),  32'(exp_valid && exp_q.size() == 1));
    exp_done = 1'b0;
    if (exp_valid && enable && !st && !reset) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) exp_done = 1'b1;
      else exp_count = exp_q[0];
    end
  endtask

  // One clock cycle with the given start/enable.
  task automatic cycle(input string tag, input bit st, input bit en);
    enable  = en;
    start_a = st && !sel;
    start_b = st && sel;
    observe(tag, st);
    if (st) begin
      exp_q.delete();
      push_seq(int'(start_addr), int'(step), int'(length), sel ? 15 : 1024);
      if (length == 0) exp_done = 1'b1;
      else exp_count = exp_q[0];
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset  = 1'b1;
    enable = 1'b1;
    observe(tag, 1'b0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_done  = 1'b0;
    exp_count = '0;
  endtask

  task automatic setup(input int a, input int s, input int len);
    start_addr = W'(a);
    step       = W'(s);
    length     = LW'(len);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    sel = 1'b0; reset = 1'b1; start_a = 0; start_b = 0; enable = 0;
    setup(0, 0, 0);
    exp_done = 0; exp_count = '0;
    tick(); tick();
    reset = 1'b0;
    cycle("reset_state", 0, 0);

    // Legacy odd walk across the 1023 -> 1 wrap.
    setup(1023, 2, 6);
    cycle("odd_start", 1, 1);
    for (int i = 0; i < 8; i++) cycle("odd_walk", 0, 1);

    // Stall pattern on a three-address walk.
    setup(200, 3, 3);
    cycle("stall_start", 1, 0);
    cycle("stall_e1", 0, 1);
    cycle("stall_e0a", 0, 0);
    cycle("stall_e0b", 0, 0);
    cycle("stall_e1b", 0, 1);
    cycle("stall_e1c", 0, 1);
    cycle("stall_done", 0, 0);
    cycle("stall_idle", 0, 0);

    // Zero length: done next cycle, count left alone.
    setup(500, 1, 0);
    cycle("len0_start", 1, 1);
    cycle("len0_done", 0, 1);
    cycle("len0_idle", 0, 0);

    // Zero step repeats the address.
    setup(77, 0, 3);
    cycle("step0_start", 1, 1);
    for (int i = 0; i < 5; i++) cycle("step0_walk", 0, 1);

    // Restart at address 5 while enable is high.
    setup(0, 5, 10);
    cycle("rst_seq_start", 1, 1);
    cycle("rst_seq_a0", 0, 1);
    setup(100, 9, 4);
    cycle("restart", 1, 1);
    for (int i = 0; i < 6; i++) cycle("restart_walk", 0, 1);

    // Random enable walk, including start accepted in DONE.
    setup(1000, 37, 8);
    cycle("rand_start", 1, 1);
    for (int i = 0; i < 30; i++) cycle("rand_walk", 0, 1'($urandom_range(0, 1)));
    setup(10, 1, 2);
    cycle("late_start", 1, 1);
    cycle("late_a0", 0, 1);
    cycle("late_a1", 0, 1);
    setup(20, 2, 2);
    cycle("start_in_done", 1, 1);
    for (int i = 0; i < 4; i++) cycle("sid_walk", 0, 1);

    // Reset mid-sequence at count 37.
    setup(30, 7, 10);
    cycle("mid_start", 1, 1);
    cycle("mid_a30", 0, 1);
    do_reset("mid_at37");
    cycle("after_reset", 0, 1);
    setup(5, 1, 2);
    cycle("post_start", 1, 1);
    for (int i = 0; i < 4; i++) cycle("post_walk", 0, 1);

    // Non-power-of-two modulus on dut_b.
    do_reset("pre_b");
    sel = 1'b1;
    cycle("b_idle", 0, 0);
    setup(12, 4, 5);
    cycle("b_start", 1, 1);
    for (int i = 0; i < 7; i++) cycle("b_walk", 0, 1);
    setup(14, 14, 6);
    cycle("b2_start", 1, 1);
    for (int i = 0; i < 8; i++) cycle("b2_walk", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addr_gen_stride.md
# addr_gen_stride

Parametrised strided address generator for the GF16 NB-LDPC message memories. It is the successor of the fixed odd-address blocking counter. It walks a programmable sequence of `length` addresses from `start_addr` in steps of `step`, modulo `LIMIT`, and advances one address per `enable`. It exposes `valid`/`last`/`done`/`busy` so the check-node and variable-node schedulers can sequence memory passes without external bookkeeping.

## Interface
- `WIDTH`, default 10: address width.
- `LEN_W`, default 10: width of the length and remaining-count fields.
- `LIMIT`, default 1024: address modulus. Must satisfy 2 ≤ `LIMIT` ≤ 2^`WIDTH`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. Sampled only at the `clk` rising edge.
- `start` in 1: load parameters and begin a sequence.
- `enable` in 1: advance to the next address (consumer accepted the current one).
- `start_addr` in `WIDTH`: first address. Sampled when `start` is accepted.
- `step` in `WIDTH`: address increment. Sampled when `start` is accepted.
- `length` in `LEN_W`: number of addresses in the sequence. Sampled when `start` is accepted.
- `count` out `WIDTH`: current address.
- `valid` out 1: `count` is a live address of the current sequence.
- `last` out 1: `valid` is high and `count` is the final address.
- `done` out 1: one-cycle pulse after the final address is consumed.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: `busy`=0, `valid`=0. `count` holds its last value.
  - RUN: `busy`=1, `valid`=1.
  - DONE: `busy`=1, `valid`=0, `done`=1.
- IDLE + `start` with `length`≠0: load `count`=`start_addr` and `remaining`=`length`−1, then go to RUN.
- IDLE + `start` with `length`=0: go to DONE. `valid` is never asserted and `count` is unchanged.
- RUN + `enable` with `remaining`≠0: `count` = (`count`+`step`) mod `LIMIT`, `remaining` decrements, stay in RUN.
- RUN + `enable` with `remaining`=0: go to DONE. `count` holds the final address.
- RUN with `enable`=0: all state holds.
- DONE → IDLE unconditionally. `start` in DONE is accepted as in IDLE, going to RUN (or back to DONE if `length`=0).
- RUN + `start` (restart): reload from the new inputs exactly as from IDLE. `start` has priority over `enable`, and no `done` pulse is issued for the aborted sequence.
- Modular add:
  - Form a `WIDTH`+1-bit sum s = `count`+`step`.
  - If s ≥ `LIMIT`, subtract `LIMIT`.
  - This is a single subtraction, so it is exact only when `count` < `LIMIT` and `step` < `LIMIT`.
- Caller guarantees `start_addr` < `LIMIT` and `step` < `LIMIT`. The RTL does not check these. A simulation-only assertion flags violations when `start` is accepted.
- `step`=0 is legal and repeats the same address `length` times.
- `last` = `valid` AND (`remaining`=0). It is combinational from registered state.
- `enable` outside RUN is ignored.
- Reset (any state, including mid-sequence): state=IDLE, `count`=0, `remaining`=0. Consequently `valid`=0, `last`=0, `done`=0, `busy`=0 in the following cycle. `reset` overrides `start` and `enable`.

## Timing
- `start` sampled at edge k → `valid`=1 and `count`=`start_addr` in cycle k+1. Load latency is 1.
- Each `enable` sampled at an edge in RUN updates `count` at that same edge. Throughput is one address per cycle with `enable` held high.
- The edge that samples `enable` with `last`=1 moves the FSM to DONE. `done`=1 for exactly that next cycle, and `busy` falls one cycle later.
- Sequence with continuous `enable`: `start` at edge k gives `valid` in cycles k+1 … k+`length`, `done` in cycle k+`length`+1, and `busy`=0 in cycle k+`length`+2.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Package `nbldpc_addr_pkg`:
  - Typedef `addr_gen_state_t` (IDLE, RUN, DONE).
  - Function `mod_add(a, b, limit)`, shared with other address generators.
- One combinational sub-module, `addr_mod_add` (parameters `WIDTH`, `LIMIT`), implementing the modular increment so it can be reused and tested alone.
- The top level holds the FSM plus the `count` and `remaining` registers.

## Test plan
- Legacy odd walk: `WIDTH`=10, `LIMIT`=1024, `start_addr`=1023, `step`=2, `length`=6, `enable` held high → `count` 1023, 1, 3, 5, 7, 9. `last` is high on 9, and `done` pulses one cycle later.
- Non-power-of-two modulus: `LIMIT`=15, `start_addr`=12, `step`=4, `length`=5 → `count` 12, 1, 5, 9, 13. No address ≥ 15 ever appears.
- Stall: `length`=3, `enable` toggling 1, 0, 0, 1, 1 → each address is held while `enable`=0. `done` pulses the cycle after the third accepted `enable`.
- Zero length and zero step:
  - `length`=0 → no `valid`, `done` in cycle k+1, `count` unchanged.
  - `step`=0, `length`=3 → the same address three times.
- Restart: during RUN at address 5, `start` with `start_addr`=100 while `enable`=1 → next `count`=100. No `done` for the aborted sequence.
- Reset mid-sequence: assert `reset` in RUN with `count`=37 → next cycle `count`=0 and `valid`, `last`, `done`, `busy` all 0. A later `start` behaves normally.
